fifo_wr_arbiter: RTL and testbench
==================================

# fifo_wr_arbiter

Round-robin write-port arbiter that shares one FIFO write port among N_REQ requesters. Each requester uses a valid/ready handshake. The granted requester may stream up to MAX_BURST words before it must release the port. The block sits in front of the FIFO's write side and runs entirely in the write clock domain. It drives the FIFO's write enable and write data, and stalls on the FIFO's full flag.

## Interface
- DATA_WIDTH, 8, width of one data word
- N_REQ, 4, number of requesters (≥2)
- MAX_BURST, 8, maximum words per grant (≥1)
- clk  in  1  write-domain clock; all logic on rising edge
- rst  in  1  reset; synchronous, active-high
- req_valid  in  N_REQ  per-requester word available
- req_data  in  N_REQ*DATA_WIDTH  requester i's word in bits [i*DATA_WIDTH +: DATA_WIDTH]
- req_ready  out  N_REQ  per-requester word accepted this cycle (one-hot or zero)
- fifo_full  in  1  FIFO full flag, sampled in the write domain
- fifo_wr_en  out  1  FIFO write strobe
- fifo_wr_data  out  DATA_WIDTH  FIFO write data
- grant_id  out  $clog2(N_REQ)  index of the current grant holder
- busy  out  1  a grant is held (state GRANT)

## Operation
- States: IDLE, GRANT. Registers: state, grant_id, rr_ptr, burst_cnt (width $clog2(MAX_BURST+1)).
- Pick function: first asserted req_valid, searching from rr_ptr upward, modulo N_REQ.
- IDLE:
  - If any req_valid is high, load grant_id with the pick, set burst_cnt=0, and go to GRANT.
  - Otherwise stay in IDLE.
- GRANT:
  - req_ready[grant_id] = !fifo_full. All other ready bits are 0.
  - A transfer occurs when req_valid[grant_id] && !fifo_full.
  - fifo_wr_en = transfer. fifo_wr_data = req_data of grant_id (combinational).
  - On a transfer, burst_cnt increments.
- Release happens in GRANT on either of these conditions:
  - (a) a transfer makes burst_cnt reach MAX_BURST, or
  - (b) req_valid[grant_id]==0.
- On release:
  - Set rr_ptr = grant_id+1 (wraps to 0 after N_REQ-1).
  - Re-pick from the new rr_ptr, using req_valid but masking bit grant_id in case (b).
  - If the pick finds a requester, load the new grant_id, clear burst_cnt and stay in GRANT. Otherwise go to IDLE.
  - The releasing requester's own transfer in case (a) still completes that cycle.
- fifo_full in GRANT: no transfer, burst_cnt holds, grant holds. Full never causes a release.
- The requester must hold req_data stable while req_valid is high and ready is low. Dropping valid mid-burst forfeits the grant.
- req_ready is never asserted in IDLE. fifo_wr_en is never asserted without a matching req_ready.

## Timing
- Reset values: state=IDLE, grant_id=0, rr_ptr=0, burst_cnt=0, req_ready=0, fifo_wr_en=0, fifo_wr_data=0 (IDLE forces 0), busy=0.
- Asserting rst mid-burst aborts the grant at the next edge. No write occurs in the reset cycle.
- Arbitration latency from IDLE is 1 cycle: valid first seen at edge t means the first possible transfer is in cycle t+1.
- A hand-over between requesters costs 0 idle cycles: the new holder can transfer in the cycle after release.
- Peak throughput is 1 word/cycle while !fifo_full.
- fifo_full feeds req_ready and fifo_wr_en combinationally, with no registered lag. The FIFO's own full guard is therefore never relied upon.
- busy equals (state==GRANT).

## Structure
- Package fifo_arb_pkg holds:
  - the state enum (IDLE, GRANT), and
  - the helper constants GNT_W=$clog2(N_REQ) and CNT_W=$clog2(MAX_BURST+1), expressed as functions of the parameters.
- Sub-module rr_picker is a purely combinational block:
  - inputs: req vector, start pointer, mask;
  - outputs: found flag and index.
- rr_picker is instantiated once and shared by the IDLE and release paths.

## Test plan
- Reset, then all requesters valid with MAX_BURST=8 and fifo_full=0:
  - Grants go 0,1,2,3,0, each delivering 8 words back-to-back.
  - The FIFO sees 32 writes in 32 cycles after the 1-cycle initial arbitration.
- Requester 2 alone valid for 3 words then drops valid:
  - 3 writes occur, the grant releases, and the state returns to IDLE.
  - rr_ptr=3, so the next pick with 1 and 3 valid goes to 3.
- fifo_full asserted for 5 cycles mid-burst (after word 4):
  - req_ready and fifo_wr_en stay 0 for exactly those cycles.
  - burst_cnt holds at 4, the grant does not change, and words 5–8 follow.
- Requester 1 holds valid continuously, requester 0 valid:
  - Requester 1 gets exactly 8 words, then the grant passes to 0 (wrap), with zero bubble cycles.
- rst asserted at word 3 of a burst:
  - The next cycle shows all outputs at their reset values and 0 writes.
  - After rst is released, arbitration restarts from requester 0.
- Data integrity: each requester sends a distinct pattern (0xA0+i, incrementing).
  - The FIFO write stream contains each requester's words in order, with none lost or duplicated.

Source files
------------

// File: rtl/fifo_wr_arbiter_pkg.sv
// Shared types and width helpers for the FIFO write-port arbiter.
// Widths are computed from the instantiating module's parameters.
package fifo_arb_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } arb_state_t;

    // GNT_W: width of a requester index.
    function automatic int gnt_w(input int n_req);
        return (n_req > 1) ? $clog2(n_req) : 1;
    endfunction

    // CNT_W: width of a burst counter that must be able to hold MAX_BURST.
    function automatic int cnt_w(input int max_burst);
        return $clog2(max_burst + 1);
    endfunction

endpackage

// File: rtl/fifo_wr_arbiter_rr_picker.sv
// Combinational round-robin search: the first eligible requester at or after
// the start pointer, wrapping modulo N_REQ.
module rr_picker
    import fifo_arb_pkg::*;
#(
    parameter int N_REQ = 4
) (
    input  logic [N_REQ-1:0]         req,
    input  logic [$clog2(N_REQ)-1:0] start,
    input  logic [N_REQ-1:0]         mask,
    output logic                     found,
    output logic [$clog2(N_REQ)-1:0] idx
);
    localparam int GNT_W = gnt_w(N_REQ);
    localparam logic [GNT_W:0] N_VAL = (GNT_W + 1)'(N_REQ);

    logic [N_REQ-1:0] eligible;
    logic [GNT_W:0]   sum_arr [N_REQ];
    logic [GNT_W-1:0] pos_arr [N_REQ];

    assign eligible = req & ~mask;

    // pos_arr[k] is the requester index k steps after start; start < N_REQ so
    // one conditional subtract is enough for the wrap.
    generate
        for (genvar gi = 0; gi < N_REQ; gi++) begin : g_pos
            assign sum_arr[gi] = {1'b0, start} + (GNT_W + 1)'(gi);
            assign pos_arr[gi] = (sum_arr[gi] >= N_VAL) ? GNT_W'(sum_arr[gi] - N_VAL)
                                                        : sum_arr[gi][GNT_W-1:0];
        end
    endgenerate

    // Scan from the farthest offset down so the nearest eligible one wins.
    always_comb begin
        found = 1'b0;
        idx   = '0;
        for (int k = N_REQ - 1; k >= 0; k--) begin
            if (eligible[pos_arr[k]]) begin
                found = 1'b1;
                idx   = pos_arr[k];
            end
        end
    end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Round-robin arbiter sharing one FIFO write port among N_REQ valid/ready
// requesters, with bursts capped at MAX_BURST words per grant.
module fifo_wr_arbiter
    import fifo_arb_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int N_REQ      = 4,
    parameter int MAX_BURST  = 8
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [N_REQ-1:0]            req_valid,
    input  logic [N_REQ*DATA_WIDTH-1:0] req_data,
    output logic [N_REQ-1:0]            req_ready,
    input  logic                        fifo_full,
    output logic                        fifo_wr_en,
    output logic [DATA_WIDTH-1:0]       fifo_wr_data,
    output logic [$clog2(N_REQ)-1:0]    grant_id,
    output logic                        busy
);
    localparam int GNT_W = gnt_w(N_REQ);
    localparam int CNT_W = cnt_w(MAX_BURST);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(MAX_BURST - 1);
    localparam logic [GNT_W-1:0] LAST_ID  = GNT_W'(N_REQ - 1);

    arb_state_t       state_reg;
    logic [GNT_W-1:0] grant_id_reg;
    logic [GNT_W-1:0] rr_ptr_reg;
    logic [CNT_W-1:0] burst_cnt_reg;

    logic [DATA_WIDTH-1:0] word_arr [N_REQ];
    logic [N_REQ-1:0]      grant_onehot;

    generate
        for (genvar gi = 0; gi < N_REQ; gi++) begin : g_req
            assign word_arr[gi]     = req_data[gi*DATA_WIDTH +: DATA_WIDTH];
            assign grant_onehot[gi] = (grant_id_reg == GNT_W'(gi));
        end
    endgenerate

    logic             in_grant;
    logic             holder_valid;
    logic             transfer;
    logic             last_word;
    logic             drop;
    logic             release_now;
    logic [GNT_W-1:0] next_ptr;
    logic [GNT_W-1:0] pick_start;
    logic [N_REQ-1:0] pick_mask;
    logic             pick_found;
    logic [GNT_W-1:0] pick_idx;

    assign in_grant     = (state_reg == GRANT);
    assign holder_valid = |(req_valid & grant_onehot);
    // Gating with rst keeps the reset cycle itself free of writes.
    assign transfer     = in_grant && holder_valid && !fifo_full && !rst;
    assign last_word    = transfer && (burst_cnt_reg == LAST_CNT);
    assign drop         = in_grant && !holder_valid;
    assign release_now  = last_word || drop;

    assign next_ptr   = (grant_id_reg == LAST_ID) ? '0 : grant_id_reg + GNT_W'(1);
    assign pick_start = in_grant ? next_ptr : rr_ptr_reg;
    // A holder that dropped valid is excluded; one that finished a full burst
    // may be re-picked if nobody else is waiting.
    assign pick_mask  = drop ? grant_onehot : '0;

    rr_picker #(
        .N_REQ(N_REQ)
    ) u_picker (
        .req   (req_valid),
        .start (pick_start),
        .mask  (pick_mask),
        .found (pick_found),
        .idx   (pick_idx)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg     <= IDLE;
            grant_id_reg  <= '0;
            rr_ptr_reg    <= '0;
            burst_cnt_reg <= '0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (pick_found) begin
                        state_reg     <= GRANT;
                        grant_id_reg  <= pick_idx;
                        burst_cnt_reg <= '0;
                    end
                end
                GRANT: begin
                    if (release_now) begin
                        rr_ptr_reg    <= next_ptr;
                        burst_cnt_reg <= '0;
                        if (pick_found) begin
                            grant_id_reg <= pick_idx;
                        end else begin
                            state_reg <= IDLE;
                        end
                    end else if (transfer) begin
                        burst_cnt_reg <= burst_cnt_reg + CNT_W'(1);
                    end
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

    assign req_ready    = (in_grant && !fifo_full && !rst) ? grant_onehot : '0;
    assign fifo_wr_en   = transfer;
    assign fifo_wr_data = in_grant ? word_arr[grant_id_reg] : '0;
    assign grant_id     = grant_id_reg;
    assign busy         = in_grant;

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Bench for fifo_wr_arbiter: a cycle model checked every negedge, directed
// phases with literal expectations, and a final data-integrity sweep.
module tb_fifo_wr_arbiter;
    localparam int DW = 8;
    localparam int N  = 4;
    localparam int MB = 8;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic [N-1:0]    req_valid = '0;
    logic [N*DW-1:0] req_data;
    logic [N-1:0]    req_ready;
    logic            fifo_full = 1'b0;
    logic            fifo_wr_en;
    logic [DW-1:0]   fifo_wr_data;
    logic [1:0]      grant_id;
    logic            busy;

    always #5 clk = ~clk;

    fifo_wr_arbiter #(
        .DATA_WIDTH (DW),
        .N_REQ      (N),
        .MAX_BURST  (MB)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .req_valid    (req_valid),
        .req_data     (req_data),
        .req_ready    (req_ready),
        .fifo_full    (fifo_full),
        .fifo_wr_en   (fifo_wr_en),
        .fifo_wr_data (fifo_wr_data),
        .grant_id     (grant_id),
        .busy         (busy)
    );

    int n_cmp = 0;
    int n_err = 0;
    int cyc_no = 0;

    int rem  [N] = '{default: 0};   // words each requester still wants to send
    int sent [N] = '{default: 0};   // words each requester has had accepted
    logic [N-1:0] acc_neg = '0;

    typedef struct {
        int gid;
        int data;
        int cyc;
    } wr_t;
    wr_t wr_log[$];

    // Requester i sends 0xA0+i, then increments per accepted word.
    always_comb begin
        req_data = '0;
        for (int i = 0; i < N; i++) req_data[i*DW +: DW] = 8'(8'hA0 + i + sent[i]);
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at t=%0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    bit  m_busy = 0;
    int  m_gid = 0, m_ptr = 0, m_cnt = 0;
    int  m_sent [N] = '{default: 0};

    function automatic int pick(input int start, input logic [N-1:0] v);
        for (int k = 0; k < N; k++) if (v[(start + k) % N]) return (start + k) % N;
        return -1;
    endfunction

    always @(posedge clk) begin
        bit nb, rel, xfer;
        int ng, np, nc, p;
        logic [N-1:0] v;
        nb = m_busy; ng = m_gid; np = m_ptr; nc = m_cnt;
        rel = 0; xfer = 0; v = req_valid; p = -1;
        if (rst) begin
            nb = 0; ng = 0; np = 0; nc = 0;
        end else if (!m_busy) begin
            p = pick(m_ptr, req_valid);
            if (p >= 0) begin nb = 1; ng = p; nc = 0; end
        end else begin
            if (!req_valid[m_gid]) begin
                rel = 1; v[m_gid] = 1'b0;
            end else if (!fifo_full) begin
                xfer = 1; nc = m_cnt + 1; rel = (nc == MB);
            end
            if (rel) begin
                np = (m_gid + 1) % N; nc = 0;
                p = pick(np, v);
                if (p >= 0) ng = p; else nb = 0;
            end
        end
        if (xfer) m_sent[m_gid] <= m_sent[m_gid] + 1;
        m_busy <= nb; m_gid <= ng; m_ptr <= np; m_cnt <= nc;
        cyc_no <= cyc_no + 1;
    end

    // Compare process: every negedge, plus write logging and handshake capture.
    always @(negedge clk) begin
        logic [N-1:0] e_ready;
        logic         e_wr;
        logic [DW-1:0] e_data;
        wr_t e;
        e_ready = (!rst && m_busy && !fifo_full) ? N'(1 << m_gid) : '0;
        e_wr    = !rst && m_busy && req_valid[m_gid] && !fifo_full;
        e_data  = m_busy ? 8'(8'hA0 + m_gid + m_sent[m_gid]) : 8'h00;
        check("req_ready", req_ready, e_ready);
        check("fifo_wr_en", fifo_wr_en, e_wr);
        check("fifo_wr_data", fifo_wr_data, e_data);
        check("grant_id", grant_id, m_gid);
        check("busy", busy, m_busy);
        if (fifo_wr_en) begin
            e.gid = int'(grant_id); e.data = int'(fifo_wr_data); e.cyc = cyc_no;
            wr_log.push_back(e);
        end
        acc_neg = req_ready & req_valid;
    end

    // ---------------- driver helpers ----------------
    task automatic apply();
        for (int i = 0; i < N; i++) req_valid[i] = (rem[i] > 0);
    endtask

    task automatic cycle();
        @(posedge clk);
        #1;
        for (int i = 0; i < N; i++) begin
            if (acc_neg[i]) begin
                sent[i]++;
                if (rem[i] > 0) rem[i]--;
            end
        end
        apply();
    endtask

    task automatic do_reset();
        for (int i = 0; i < N; i++) rem[i] = 0;
        apply();
        rst = 1'b1;
        cycle();
        rst = 1'b0;
    endtask

    function automatic int log_gid(input int idx);
        if (idx < wr_log.size()) return wr_log[idx].gid;
        return -1;
    endfunction

    function automatic int log_data(input int idx);
        if (idx < wr_log.size()) return wr_log[idx].data;
        return -1;
    endfunction

    function automatic int log_cyc(input int idx);
        if (idx < wr_log.size()) return wr_log[idx].cyc;
        return -1;
    endfunction

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int base, base2, t;
        int cntg [N];

        // Reset state
        rst = 1'b1;
        repeat (2) cycle();
        rst = 1'b0;
        check("rst_busy", busy, 0);
        check("rst_grant_id", grant_id, 0);
        check("rst_req_ready", req_ready, 0);
        check("rst_wr_en", fifo_wr_en, 0);
        check("rst_wr_data", fifo_wr_data, 0);

        // All requesters valid: grants 0,1,2,3,0, 32 back-to-back writes
        base = wr_log.size();
        for (int i = 0; i < N; i++) rem[i] = 1000;
        apply();
        repeat (33) cycle();
        check("t1_writes", wr_log.size() - base, 32);
        check("t1_span", log_cyc(base + 31) - log_cyc(base), 31);
        for (int k = 0; k < 4; k++) check("t1_burst_gid", log_gid(base + 8*k), k);
        check("t1_first_data", log_data(base), 8'hA0);
        check("t1_last0_data", log_data(base + 7), 8'hA7);
        check("t1_first1_data", log_data(base + 8), 8'hA1);
        check("t1_wrap_gid", grant_id, 0);
        check("t1_wrap_busy", busy, 1);

        // Requester 2 alone for 3 words, then drops valid
        do_reset();
        base = wr_log.size();
        rem[2] = 3;
        apply();
        repeat (6) cycle();
        check("t2_writes", wr_log.size() - base, 3);
        check("t2_gid", log_gid(base), 2);
        check("t2_idle", busy, 0);
        base = wr_log.size();
        rem[1] = 2; rem[3] = 2;
        apply();
        repeat (2) cycle();
        check("t2_next_pick", log_gid(base), 3);
        repeat (8) cycle();

        // fifo_full for 5 cycles after word 4
        do_reset();
        base = wr_log.size();
        rem[0] = 1000; rem[1] = 1000;
        apply();
        t = 0;
        while (wr_log.size() - base < 4 && t < 20) begin cycle(); t++; end
        check("t3_pre_writes", wr_log.size() - base, 4);
        fifo_full = 1'b1;
        repeat (5) cycle();
        check("t3_stall_writes", wr_log.size() - base, 4);
        check("t3_stall_busy", busy, 1);
        check("t3_stall_gid", grant_id, 0);
        fifo_full = 1'b0;
        repeat (4) cycle();
        check("t3_post_writes", wr_log.size() - base, 8);
        check("t3_word8_gid", log_gid(base + 7), 0);
        cycle();
        check("t3_handover_gid", log_gid(base + 8), 1);
        check("t3_handover_gap", log_cyc(base + 8) - log_cyc(base + 7), 1);

        // Requester 1 gets exactly 8 words, then wrap to requester 0
        repeat (8) cycle();
        check("t4_writes", wr_log.size() - base, 17);
        check("t4_last1_gid", log_gid(base + 15), 1);
        check("t4_wrap_gid", log_gid(base + 16), 0);
        check("t4_wrap_gap", log_cyc(base + 16) - log_cyc(base + 8), 8);

        // rst at word 3 of requester 3's burst
        rem[0] = 0; rem[1] = 0; rem[2] = 0; rem[3] = 1000;
        apply();
        base = wr_log.size();
        t = 0;
        while (wr_log.size() - base < 2 && t < 20) begin cycle(); t++; end
        check("t5_pre_gid", log_gid(base), 3);
        rst = 1'b1;
        cycle();
        rst = 1'b0;
        check("t5_rst_writes", wr_log.size() - base, 2);
        check("t5_rst_busy", busy, 0);
        check("t5_rst_gid", grant_id, 0);
        check("t5_rst_ready", req_ready, 0);
        check("t5_rst_wr_en", fifo_wr_en, 0);
        check("t5_rst_data", fifo_wr_data, 0);
        rem[0] = 2;
        apply();
        base2 = wr_log.size();
        repeat (3) cycle();
        check("t5_restart_gid", log_gid(base2), 0);
        repeat (10) cycle();

        // Data integrity: each requester's words arrive in order, none lost
        for (int i = 0; i < N; i++) cntg[i] = 0;
        foreach (wr_log[k]) begin
            check("integrity", wr_log[k].data, (8'hA0 + wr_log[k].gid + cntg[wr_log[k].gid]) & 8'hFF);
            cntg[wr_log[k].gid]++;
        end
        for (int i = 0; i < N; i++) check("integrity_count", cntg[i], sent[i]);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
